// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter in front of a single-port synchronous data memory.
// Optional debug starvation guard is compiled in with `define DMEM_ARB_STARVE_EN.
//
// state   | meaning
// IDLE    | no read outstanding
// RD_CPU  | core read issued last cycle, mem_rdata belongs to the core
// RD_DBG  | debug read issued last cycle, mem_rdata belongs to the debug port
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_write,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
            $error("dmem_arbiter: MAX_WAIT must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DBG = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   force_dbg;

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned CNT_W = 4;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    assign force_dbg = dbg_req && (wait_cnt == CNT_W'(MAX_WAIT));

    always_comb begin
        wait_cnt_nxt = '0;
        if (dbg_req && !dbg_gnt) begin
            wait_cnt_nxt = (wait_cnt == CNT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wait_cnt <= '0;
        else          wait_cnt <= wait_cnt_nxt;
    end
`else
    assign force_dbg = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Grants are gated by reset_n so every output reads zero while reset is held.
    always_comb begin
        cpu_gnt   = reset_n && cpu_req && !force_dbg;
        dbg_gnt   = reset_n && dbg_req && (force_dbg || !cpu_req);
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_nxt = IDLE;
        if (cpu_gnt) begin
            mem_write = cpu_write;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_write) state_nxt = RD_CPU;
        end else if (dbg_gnt) begin
            mem_write = dbg_write;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            if (!dbg_write) state_nxt = RD_DBG;
        end
    end

    always_comb begin
        cpu_rvalid = (state == RD_CPU);
        dbg_rvalid = (state == RD_DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, corner sequences and a
// randomized run against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cpu_req, cpu_write, dbg_req, dbg_write;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
    logic              cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_write;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous memory behind the arbiter, preloaded while mem_ready is low.
    logic [DATA_W-1:0] tbmem [64];
    logic              mem_ready = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) tbmem[i] <= init_word(i);
        end else if (mem_write) begin
            tbmem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= tbmem[mem_addr];
    end

    // Reference model state
    int          m_wait;
    logic [31:0] m_mem [64];
    bit          p_valid, p_owner;
    logic [31:0] p_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic              s_cg, s_dg, s_mw, s_crv, s_drv;
    logic [ADDR_W-1:0] s_ma;
    logic [DATA_W-1:0] s_md, s_crd, s_drd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic cr, input logic cw, input logic [5:0] ca, input logic [31:0] cd,
                          input logic dr, input logic dw, input logic [5:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_write = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    task automatic idle_in();
        set_in(0, 0, 6'd0, 32'd0, 0, 0, 6'd0, 32'd0);
    endtask

    // One clock cycle: sample at negedge, compare against the model, advance the model.
    task automatic tick();
        logic        e_cg, e_dg, e_mw, e_crv, e_drv, frc;
        logic [5:0]  e_ma;
        logic [31:0] e_md, e_crd, e_drd;
        @(negedge clk);
        s_cg = cpu_gnt; s_dg = dbg_gnt; s_mw = mem_write; s_ma = mem_addr; s_md = mem_wdata;
        s_crv = cpu_rvalid; s_crd = cpu_rdata; s_drv = dbg_rvalid; s_drd = dbg_rdata;
        {e_cg, e_dg, e_mw, e_crv, e_drv} = '0;
        e_ma = '0; e_md = '0; e_crd = '0; e_drd = '0;
        if (!reset_n) begin
            p_valid = 0;
            m_wait  = 0;
        end else begin
            frc  = STARVE_EN && dbg_req && (m_wait >= MAX_WAIT);
            e_cg = cpu_req && !frc;
            e_dg = dbg_req && !e_cg;
            if (e_cg)      begin e_mw = cpu_write; e_ma = cpu_addr; e_md = cpu_wdata; end
            else if (e_dg) begin e_mw = dbg_write; e_ma = dbg_addr; e_md = dbg_wdata; end
            e_crv = p_valid && !p_owner;
            e_drv = p_valid && p_owner;
            if (e_crv) e_crd = p_data;
            if (e_drv) e_drd = p_data;
        end
        chk("cpu_gnt", s_cg, e_cg);
        chk("dbg_gnt", s_dg, e_dg);
        chk("mem_write", s_mw, e_mw);
        chk("mem_addr", s_ma, e_ma);
        chk("mem_wdata", s_md, e_md);
        chk("cpu_rvalid", s_crv, e_crv);
        chk("cpu_rdata", s_crd, e_crd);
        chk("dbg_rvalid", s_drv, e_drv);
        chk("dbg_rdata", s_drd, e_drd);
        if (reset_n) begin
            p_valid = 0;
            if (e_cg && !cpu_write)      begin p_valid = 1; p_owner = 0; p_data = m_mem[cpu_addr]; end
            else if (e_dg && !dbg_write) begin p_valid = 1; p_owner = 1; p_data = m_mem[dbg_addr]; end
            if (e_mw) m_mem[e_ma] = e_md;
            if (STARVE_EN && dbg_req && !e_dg) begin
                if (m_wait < MAX_WAIT) m_wait++;
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic cr, cw; logic [5:0] ca; logic [31:0] cd;
        logic dr, dw; logic [5:0] da; logic [31:0] dd;
        logic e_cg, e_dg, e_mw; logic [5:0] e_ma; logic [31:0] e_md;
    } vec_t;
    vec_t vt [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1,0,6'd10,32'h00001111, 0,0,6'd0,32'h0,         1,0,0,6'd10,32'h00001111};
        vt[1] = '{1,1,6'd20,32'hAAAA5555, 0,0,6'd0,32'h0,         1,0,1,6'd20,32'hAAAA5555};
        vt[2] = '{0,0,6'd0,32'h0,         1,0,6'd30,32'h00000077, 0,1,0,6'd30,32'h00000077};
        vt[3] = '{0,0,6'd0,32'h0,         1,1,6'd40,32'hCAFEF00D, 0,1,1,6'd40,32'hCAFEF00D};
        vt[4] = '{1,1,6'd7,32'h01234567,  1,1,6'd9,32'h89ABCDEF,  1,0,1,6'd7,32'h01234567};
        vt[5] = '{0,1,6'd11,32'h11111111, 0,1,6'd12,32'h22222222, 0,0,0,6'd0,32'h0};

        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
        m_wait = 0; p_valid = 0; p_owner = 0; p_data = '0;

        // Reset held with live requests: everything must read zero.
        set_in(1, 1, 6'd33, 32'hFFFF0000, 1, 0, 6'd44, 32'h0000FFFF);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        tick();
        tick();

        // Release and read word 5 in the very first cycle.
        reset_n = 1'b1;
        set_in(1, 0, 6'd5, 32'd0, 0, 0, 6'd0, 32'd0);
        tick();
        chk("first_grant", s_cg, 1'b1);
        idle_in();
        tick();
        chk("rd5_rvalid", s_crv, 1'b1);
        chk("rd5_rdata", s_crd, 32'hDEADBEEF);
        chk("rd5_dbg_rvalid", s_drv, 1'b0);

        // Table vectors, each followed by an idle cycle.
        for (int i = 0; i < 6; i++) begin
            set_in(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
            tick();
            chk($sformatf("vec%0d_cpu_gnt", i), s_cg, vt[i].e_cg);
            chk($sformatf("vec%0d_dbg_gnt", i), s_dg, vt[i].e_dg);
            chk($sformatf("vec%0d_mem_write", i), s_mw, vt[i].e_mw);
            chk($sformatf("vec%0d_mem_addr", i), s_ma, vt[i].e_ma);
            chk($sformatf("vec%0d_mem_wdata", i), s_md, vt[i].e_md);
            idle_in();
            tick();
        end

        // Debug write to the top word, then core reads it back.
        set_in(0, 0, 6'd0, 32'd0, 1, 1, 6'd63, 32'h12345678);
        tick();
        chk("dbgwr_mem_write", s_mw, 1'b1);
        chk("dbgwr_mem_addr", s_ma, 6'd63);
        set_in(1, 0, 6'd63, 32'd0, 0, 0, 6'd0, 32'd0);
        tick();
        chk("rd63_gnt", s_cg, 1'b1);
        idle_in();
        tick();
        chk("rd63_rvalid", s_crv, 1'b1);
        chk("rd63_rdata", s_crd, 32'h12345678);

        // Back-to-back reads to alternating ports.
        set_in(1, 0, 6'd1, 32'd0, 0, 0, 6'd0, 32'd0);
        tick();
        set_in(0, 0, 6'd0, 32'd0, 1, 0, 6'd2, 32'd0);
        tick();
        chk("alt_cpu_rvalid", s_crv, 1'b1);
        chk("alt_cpu_rdata", s_crd, init_word(1));
        idle_in();
        tick();
        chk("alt_dbg_rvalid", s_drv, 1'b1);
        chk("alt_dbg_rdata", s_drd, init_word(2));
        chk("alt_cpu_rvalid_off", s_crv, 1'b0);

        // Both ports requesting continuously.
        set_in(1, 0, 6'd3, 32'd0, 1, 0, 6'd4, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("starve_c%0d_dbg_gnt", c), s_dg, STARVE_EN && (c == 5 || c == 10));
            chk($sformatf("starve_c%0d_cpu_gnt", c), s_cg, !(STARVE_EN && (c == 5 || c == 10)));
        end
        idle_in();
        tick();

        // Reset pulled low the cycle after a granted read.
        set_in(1, 0, 6'd8, 32'd0, 0, 0, 6'd0, 32'd0);
        tick();
        reset_n = 1'b0;
        set_in(1, 1, 6'd9, 32'hFEEDFACE, 1, 0, 6'd10, 32'd0);
        tick();
        chk("rst_cpu_rvalid", s_crv, 1'b0);
        chk("rst_cpu_gnt", s_cg, 1'b0);
        tick();
        reset_n = 1'b1;
        idle_in();
        tick();
        chk("post_rst_cpu_rvalid", s_crv, 1'b0);
        chk("post_rst_dbg_rvalid", s_drv, 1'b0);

        // Randomized traffic; a denied requester usually holds its request.
        for (int i = 0; i < 600; i++) begin
            if (!(cpu_req && !s_cg && $urandom_range(0, 3) != 0)) begin
                cpu_req   = ($urandom_range(0, 9) < 6);
                cpu_write = ($urandom_range(0, 2) == 0);
                cpu_addr  = 6'($urandom);
                cpu_wdata = $urandom;
            end
            if (!(dbg_req && !s_dg && $urandom_range(0, 7) != 0)) begin
                dbg_req   = ($urandom_range(0, 9) < 5);
                dbg_write = ($urandom_range(0, 2) == 0);
                dbg_addr  = 6'($urandom);
                dbg_wdata = $urandom;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 6, data memory word-address width.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive denied cycles before the debug port is forced a grant (range 1..15).

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  core requests memory access this cycle.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  core request accepted this cycle.
- cpu_rvalid  out  1  core read data valid.
- cpu_rdata  out  DATA_W  core read data.
- dbg_req, dbg_write, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug/loader request, same meaning as the cpu_* inputs.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  same meaning as the cpu_* outputs.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous memory read data, valid one cycle after the address.

Function
REQ-003 The grant SHALL be combinational in the request cycle, with at most one of cpu_gnt/dbg_gnt high per cycle.
REQ-004 Default priority: cpu_req wins; dbg_gnt = dbg_req & ~cpu_req, except under REQ-008.
REQ-005 The granted port's write/addr/wdata SHALL drive mem_*; mem_write = gnt & write.
REQ-006 With no grant: mem_write = 0, mem_addr = 0, mem_wdata = 0.
REQ-007 A granted read SHALL set a pending flag and an owner register. Next cycle, the owner's rvalid = 1 and its rdata = mem_rdata; the non-owner's rvalid = 0 and its rdata = 0.
REQ-008 Starvation guard, when compiled in:
- wait_cnt increments each cycle dbg_req = 1 and dbg_gnt = 0, saturating at MAX_WAIT.
- When wait_cnt = MAX_WAIT and dbg_req = 1: dbg_gnt = 1 and cpu_gnt = 0 that cycle.
REQ-009 wait_cnt SHALL clear on any dbg_gnt, or in any cycle dbg_req = 0.
REQ-010 Request inputs SHALL only be sampled when req = 1; a denied requester holds its request, and the arbiter does not queue.
REQ-011 Back-to-back reads to alternating ports SHALL each return rvalid exactly one cycle later, with no bubble.
REQ-012 Writes SHALL produce no rvalid.

Reset
REQ-013 While reset_n = 0, the outputs SHALL be:
- cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_write = 0.
- mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0.
REQ-014 Reset asserted mid-read SHALL clear the pending flag, owner and wait_cnt immediately; no rvalid is issued after release.
REQ-015 The first grant SHALL be possible in the first rising edge cycle after reset_n deasserts.

Configuration
REQ-016 Macro DMEM_ARB_STARVE_EN:
- Defined: REQ-008 and REQ-009 apply.
- Undefined: wait_cnt does not exist; priority is pure cpu-first per REQ-004, and dbg can starve indefinitely.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- cpu read addr 5, memory word 5 = 0xDEADBEEF -> cpu_gnt = 1 same cycle; next cycle cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF, dbg_rvalid = 0.
- cpu_req and dbg_req both held continuously, MAX_WAIT = 4, macro defined -> cpu_gnt cycles 1-4, dbg_gnt cycle 5, cpu_gnt cycles 6-9, dbg_gnt cycle 10.
- Same stimulus, macro undefined -> cpu_gnt every cycle, dbg_gnt never.
- dbg write 0x12345678 to addr 63, then cpu read addr 63 -> mem_write = 1 with addr 63 on the write cycle; cpu_rdata = 0x12345678 one cycle after the read grant.
- Read cpu addr 1 then dbg addr 2 on consecutive cycles -> cpu_rvalid, then dbg_rvalid on consecutive cycles, each with the correct data.
- reset_n pulled low in the cycle after a granted read -> no rvalid; all outputs 0 until release.
